// File: rtl/mb_conf_builder.sv
// Producer side of the mb_conf FIFO: counts per-sign events for one macroblock
// and writes a packed {mb_conf, first_group, has_one_group} word on its last event.
module mb_conf_builder #(
  parameter int CNT_W   = 7,
  parameter int N_GROUP = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic [5:0]                            sign_ev,
  input  logic                                  sign_ev_empty,
  output logic                                  sign_ev_rd,
  input  logic                                  mb_conf_afull,
  output logic [CNT_W*(2*N_GROUP+1)-1:0]        mb_conf,
  output logic [2:0]                            first_group,
  output logic                                  has_one_group,
  output logic                                  mb_conf_wr,
  output logic                                  cfg_err
);

  localparam int N_FLD  = 2*N_GROUP + 1;
  localparam int CONF_W = CNT_W*N_FLD;
  localparam int IDX_W  = $clog2(N_FLD);

  // Handshake: a read is issued whenever the source has data and the sink has
  // room; the event is then valid on sign_ev exactly one enabled cycle later (rd_q).
  assign sign_ev_rd = clk_en & ~rst & ~sign_ev_empty & ~mb_conf_afull;

  logic             ev_last, ev_no_sign, ev_sel;
  logic [2:0]       ev_grp;
  assign ev_last    = sign_ev[5];
  assign ev_no_sign = sign_ev[4];
  assign ev_sel     = sign_ev[3];
  assign ev_grp     = sign_ev[2:0];

  logic             rd_q;
  logic [CNT_W-1:0] cnt      [N_FLD];
  logic [CNT_W-1:0] cnt_nxt  [N_FLD];
  logic [CNT_W-1:0] snap     [N_FLD];
  logic             snap_v;
  logic             wr_q;

  logic             inc_hit;
  logic [IDX_W-1:0] inc_idx;
  logic             bad_grp;
  logic             sat_hit;

  always_comb begin
    inc_hit = 1'b0;
    inc_idx = '0;
    bad_grp = 1'b0;
    if (rd_q && !ev_no_sign) begin
      if (ev_grp == 3'd0) begin
        inc_hit = 1'b1;
      end else if (int'(ev_grp) > N_GROUP) begin
        bad_grp = 1'b1;
      end else begin
        inc_hit = 1'b1;
        // selected lands on field 2g-1, unselected on field 2g
        inc_idx = IDX_W'({ev_grp, 1'b0}) - IDX_W'(ev_sel);
      end
    end
  end

  always_comb begin
    sat_hit = 1'b0;
    for (int k = 0; k < N_FLD; k++) begin
      cnt_nxt[k] = cnt[k];
      if (inc_hit && inc_idx == IDX_W'(k)) begin
        if (&cnt[k]) sat_hit = 1'b1;
        else         cnt_nxt[k] = cnt[k] + 1'b1;
      end
    end
  end

  logic [N_GROUP:0] grp_nz;
  logic [2:0]       fg_nxt;
  logic             one_nxt;
  logic [CONF_W-1:0] conf_nxt;

  always_comb begin
    grp_nz[0] = |snap[0];
    for (int g = 1; g <= N_GROUP; g++) begin
      grp_nz[g] = (|snap[2*g-1]) | (|snap[2*g]);
    end
    fg_nxt = 3'd7;
    for (int g = N_GROUP; g >= 0; g--) begin
      if (grp_nz[g]) fg_nxt = 3'(g);
    end
    one_nxt  = ($countones(grp_nz) == 1);
    conf_nxt = '0;
    for (int k = 0; k < N_FLD; k++) begin
      conf_nxt[CONF_W-1-CNT_W*k -: CNT_W] = snap[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q          <= 1'b0;
      snap_v        <= 1'b0;
      wr_q          <= 1'b0;
      mb_conf       <= '0;
      first_group   <= '0;
      has_one_group <= 1'b0;
      cfg_err       <= 1'b0;
      for (int k = 0; k < N_FLD; k++) begin
        cnt[k]  <= '0;
        snap[k] <= '0;
      end
    end else if (clk_en) begin
      rd_q <= sign_ev_rd;
      if (sat_hit || bad_grp) cfg_err <= 1'b1;
      // counters restart at the same edge the snapshot is taken
      if (rd_q && ev_last) begin
        snap   <= cnt_nxt;
        snap_v <= 1'b1;
        for (int k = 0; k < N_FLD; k++) cnt[k] <= '0;
      end else begin
        cnt    <= cnt_nxt;
        snap_v <= 1'b0;
      end
      wr_q <= snap_v;
      if (snap_v) begin
        mb_conf       <= conf_nxt;
        first_group   <= fg_nxt;
        has_one_group <= one_nxt;
      end
    end
  end

  // A pending write waits out clk_en low and fires once when it returns.
  assign mb_conf_wr = wr_q & clk_en;

endmodule

// File: doc/mb_conf_builder.md
Name: mb_conf_builder

Overview:
Producer end of the mb_conf FIFO consumed by sign_switcher. Reads a per-sign event stream for each macroblock and accumulates 13 saturating 7-bit counts (motion, then selected/unselected for groups 1..6). On the macroblock's last event it writes one packed word {mb_conf, first_group, has_one_group} into the mb_conf FIFO.

Parameters:
CNT_W, 7, width of each count field
N_GROUP, 6, number of selectable groups; mb_conf width = CNT_W*(2*N_GROUP+1) = 91

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clk_en  in  1  global enable; when low all state holds and rd/wr strobes are 0
sign_ev  in  6  event from sign_ev FIFO: [5] last, [4] no_sign, [3] selected, [2:0] group (0 = motion, 1..6 = group)
sign_ev_empty  in  1  sign_ev FIFO empty
sign_ev_rd  out  1  read strobe; data is valid on sign_ev the cycle after
mb_conf_afull  in  1  mb_conf FIFO almost full; asserted with at least 3 free entries
mb_conf  out  91  field k (k = 0..12) at [90-7k : 84-7k]; k0 = motion, k(2g-1) = selected gN, k(2g) = unselected gN
first_group  out  3  lowest group index (0..6) with a nonzero count; 7 if none
has_one_group  out  1  exactly one group has a nonzero count (motion is group 0; group g>0 counts if selected or unselected > 0)
mb_conf_wr  out  1  write strobe to mb_conf FIFO
cfg_err  out  1  sticky: a count saturated, or an event carried group 7 without no_sign

Behaviour:
- Reset: sign_ev_rd=0, mb_conf_wr=0, mb_conf=0, first_group=0, has_one_group=0, cfg_err=0. Counters and pipeline are cleared. Any partial macroblock is discarded; a read in flight at reset is ignored.
- All registers advance only when clk_en=1.
- Read issue: sign_ev_rd = clk_en & ~rst & ~sign_ev_empty & ~mb_conf_afull. Back-to-back reads are allowed. rd_q is a registered copy of sign_ev_rd and marks a valid event on sign_ev.
- Accumulate, on rd_q:
  - no_sign=1: no increment.
  - group=0: increment k0. selected is ignored.
  - group g in 1..6: increment k(2g-1) if selected=1, else k(2g).
  - group=7 with no_sign=0: no increment; set cfg_err.
  - Increments saturate at 127; an attempted increment at 127 sets cfg_err.
- Last event, on rd_q & last (cycle N):
  - Stage-1 snapshot <= counters + this event's increment.
  - Counters clear at the same edge, so an event read in cycle N (arriving N+1) is the first event of the next macroblock. No event is lost or double counted.
- Stage 2 (cycle N+1): compute first_group and has_one_group from the snapshot, register all outputs, assert mb_conf_wr for exactly one cycle at N+2. Latency from last-event data valid to mb_conf_wr is 2 cycles.
- The pipeline holds at most 2 macroblocks in flight, which is why afull must leave 3 free entries. Outputs hold their value between writes.
- Empty macroblock (only no_sign/last events, or all zero): written with mb_conf=0, first_group=7, has_one_group=0.
- Consecutive last events on successive cycles produce mb_conf_wr on successive cycles, each with the correct snapshot.
- clk_en low mid-macroblock: counters, rd_q, snapshot and stage-2 registers freeze. A pending wr is delayed until clk_en returns and is never dropped or duplicated.
- No write ever occurs while mb_conf_afull was high at the time of the corresponding read. Reads stop the cycle afull rises; in-flight macroblocks (at most 2) still write.

Test Plan:
- Single motion event {last=1, no_sign=0, group=0} -> one write 2 cycles after data valid: mb_conf={7'd1,{12{7'd0}}}, first_group=0, has_one_group=1.
- Two events: group=6 selected=1 ×10, group=0 ×2, last on the final one -> mb_conf={7'd2,{10{7'd0}},7'd10,7'd0}, first_group=0, has_one_group=0.
- Back-to-back macroblocks: group=2 selected (last), then group=1 unselected (last) on consecutive reads -> two writes on consecutive cycles: first has field k3=1, first_group=2, has_one_group=1; second has field k2=1, first_group=1, has_one_group=1.
- 130 events of group=3 selected=0 then last -> field k6=127, cfg_err=1 and sticky until rst.
- mb_conf_afull raised mid-stream -> sign_ev_rd drops the same cycle, already-read macroblocks still write, reads resume when afull falls, and total written counts match the stimulus.
- rst pulsed after 5 events of a macroblock -> no write for that macroblock; the next macroblock {group=4 selected, last} gives field k7=1 only, first_group=4.
